// File: rtl/waypoint_path_sequencer.sv
// rtl/waypoint_path_sequencer.sv - captures start/end/waypoint tags, then queries each segment
// and multiplies the segment path counts into a single result.
module waypoint_path_sequencer #(
   parameter int TAG_W         = 12,
   parameter int NUM_WAYPOINTS = 2,
   parameter int NUM_PATHS_DW  = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [TAG_W-1:0]         i_tag,
   input  logic                     i_tag_vld,
   input  logic                     i_is_start,
   input  logic                     i_is_end,
   input  logic [NUM_WAYPOINTS-1:0] i_wp_hit,
   input  logic                     i_input_done,
   input  logic                     i_mode,
   output logic                     o_qry_vld,
   output logic [TAG_W-1:0]         o_qry_src,
   output logic [TAG_W-1:0]         o_qry_dst,
   input  logic                     i_qry_rdy,
   input  logic                     i_cnt_vld,
   input  logic [NUM_PATHS_DW-1:0]  i_cnt,
   output logic [NUM_PATHS_DW-1:0]  o_result,
   output logic                     o_result_vld,
   output logic                     o_overflow,
   output logic                     o_error
);

   localparam int SEG_W = $clog2(NUM_WAYPOINTS + 2);
   localparam int PW    = 2 * NUM_PATHS_DW;

   typedef enum logic [2:0] {
      S_CAPTURE,
      S_ISSUE,
      S_WAIT_CNT,
      S_DONE,
      S_ERR
   } state_t;

   state_t                   state;
   logic [TAG_W-1:0]         start_tag, end_tag;
   logic [TAG_W-1:0]         wp_tag [NUM_WAYPOINTS];
   logic                     start_seen, end_seen;
   logic [NUM_WAYPOINTS-1:0] wp_seen;
   logic                     mode_q;
   logic [SEG_W-1:0]         seg;
   logic [NUM_PATHS_DW-1:0]  acc;

   logic [TAG_W-1:0]         start_nxt, end_nxt;
   logic [TAG_W-1:0]         wp_nxt [NUM_WAYPOINTS];
   logic                     start_seen_nxt, end_seen_nxt;
   logic [NUM_WAYPOINTS-1:0] wp_seen_nxt;
   logic                     req_ok;
   logic [SEG_W-1:0]         sel_seg;
   logic                     sel_mode;
   logic [TAG_W-1:0]         sel_src, sel_dst;
   logic [SEG_W-1:0]         last_seg;
   logic [PW-1:0]            prod;

   // Next-state tag view so a tag arriving with i_input_done counts immediately.
   always_comb begin
      start_nxt      = start_tag;
      end_nxt        = end_tag;
      start_seen_nxt = start_seen;
      end_seen_nxt   = end_seen;
      wp_seen_nxt    = wp_seen;
      for (int k = 0; k < NUM_WAYPOINTS; k++) begin
         wp_nxt[k] = wp_tag[k];
      end
      if (state == S_CAPTURE && i_tag_vld) begin
         if (i_is_start) begin
            start_nxt      = i_tag;
            start_seen_nxt = 1'b1;
         end
         if (i_is_end) begin
            end_nxt      = i_tag;
            end_seen_nxt = 1'b1;
         end
         for (int k = 0; k < NUM_WAYPOINTS; k++) begin
            if (i_wp_hit[k]) begin
               wp_nxt[k]      = i_tag;
               wp_seen_nxt[k] = 1'b1;
            end
         end
      end
   end

   assign req_ok = start_seen_nxt & end_seen_nxt & (~i_mode | (&wp_seen_nxt));

   // Endpoints of the segment about to be issued: seg 0 on entry, seg+1 afterwards.
   always_comb begin
      sel_seg  = (state == S_CAPTURE) ? '0 : seg + SEG_W'(1);
      sel_mode = (state == S_CAPTURE) ? i_mode : mode_q;
      sel_src  = start_nxt;
      sel_dst  = end_nxt;
      if (sel_mode) begin
         for (int k = 0; k < NUM_WAYPOINTS; k++) begin
            if (sel_seg == SEG_W'(k + 1)) sel_src = wp_nxt[k];
            if (sel_seg == SEG_W'(k))     sel_dst = wp_nxt[k];
         end
      end
   end

   assign last_seg = mode_q ? SEG_W'(NUM_WAYPOINTS) : '0;
   assign prod     = PW'(acc) * PW'(i_cnt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_CAPTURE;
         start_tag    <= '0;
         end_tag      <= '0;
         for (int k = 0; k < NUM_WAYPOINTS; k++) wp_tag[k] <= '0;
         start_seen   <= 1'b0;
         end_seen     <= 1'b0;
         wp_seen      <= '0;
         mode_q       <= 1'b0;
         seg          <= '0;
         acc          <= NUM_PATHS_DW'(1);
         o_qry_vld    <= 1'b0;
         o_qry_src    <= '0;
         o_qry_dst    <= '0;
         o_result     <= '0;
         o_result_vld <= 1'b0;
         o_overflow   <= 1'b0;
         o_error      <= 1'b0;
      end else begin
         o_result_vld <= 1'b0;
         case (state)
            S_CAPTURE: begin
               start_tag  <= start_nxt;
               end_tag    <= end_nxt;
               for (int k = 0; k < NUM_WAYPOINTS; k++) wp_tag[k] <= wp_nxt[k];
               start_seen <= start_seen_nxt;
               end_seen   <= end_seen_nxt;
               wp_seen    <= wp_seen_nxt;
               if (i_input_done) begin
                  mode_q <= i_mode;
                  if (req_ok) begin
                     state     <= S_ISSUE;
                     acc       <= NUM_PATHS_DW'(1);
                     seg       <= '0;
                     o_qry_vld <= 1'b1;
                     o_qry_src <= sel_src;
                     o_qry_dst <= sel_dst;
                  end else begin
                     state   <= S_ERR;
                     o_error <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (i_qry_rdy) begin
                  o_qry_vld <= 1'b0;
                  state     <= S_WAIT_CNT;
               end
            end
            S_WAIT_CNT: begin
               if (i_cnt_vld) begin
                  acc <= prod[NUM_PATHS_DW-1:0];
                  if (|prod[PW-1:NUM_PATHS_DW]) o_overflow <= 1'b1;
                  if (i_cnt == '0 || seg == last_seg) begin
                     state        <= S_DONE;
                     o_result     <= prod[NUM_PATHS_DW-1:0];
                     o_result_vld <= 1'b1;
                  end else begin
                     seg       <= seg + SEG_W'(1);
                     state     <= S_ISSUE;
                     o_qry_vld <= 1'b1;
                     o_qry_src <= sel_src;
                     o_qry_dst <= sel_dst;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_waypoint_path_sequencer.sv
// tb/tb_waypoint_path_sequencer.sv - scoreboard bench for waypoint_path_sequencer
// (64-bit/two-waypoint instance and an 8-bit/one-waypoint instance for overflow).
module tb_waypoint_path_sequencer;

   logic        clk;
   logic        rst;
   logic [11:0] tag;
   logic        tag_vld, is_start, is_end, input_done, mode;
   logic [1:0]  wp_hit;
   logic        qry_rdy, cnt_vld;
   logic [63:0] cnt;

   logic        a_qry_vld, a_result_vld, a_overflow, a_error;
   logic [11:0] a_src, a_dst;
   logic [63:0] a_result;
   logic        b_qry_vld, b_result_vld, b_overflow, b_error;
   logic [11:0] b_src, b_dst;
   logic [7:0]  b_result;

   logic        use8;
   logic        m_qry_vld, m_result_vld, m_overflow, m_error;
   logic [11:0] m_src, m_dst;
   logic [63:0] m_result;

   int total = 0;
   int bad   = 0;
   int pulses = 0;
   logic [23:0] exp_q [$];
   logic [64:0] exp_r [$];
   logic [23:0] eq;
   logic [64:0] er;

   waypoint_path_sequencer #(.TAG_W(12), .NUM_WAYPOINTS(2), .NUM_PATHS_DW(64)) dut (
      .clk(clk), .rst(rst), .i_tag(tag), .i_tag_vld(tag_vld), .i_is_start(is_start),
      .i_is_end(is_end), .i_wp_hit(wp_hit), .i_input_done(input_done), .i_mode(mode),
      .o_qry_vld(a_qry_vld), .o_qry_src(a_src), .o_qry_dst(a_dst), .i_qry_rdy(qry_rdy),
      .i_cnt_vld(cnt_vld), .i_cnt(cnt), .o_result(a_result), .o_result_vld(a_result_vld),
      .o_overflow(a_overflow), .o_error(a_error)
   );

   waypoint_path_sequencer #(.TAG_W(12), .NUM_WAYPOINTS(1), .NUM_PATHS_DW(8)) dut8 (
      .clk(clk), .rst(rst), .i_tag(tag), .i_tag_vld(tag_vld), .i_is_start(is_start),
      .i_is_end(is_end), .i_wp_hit(wp_hit[0:0]), .i_input_done(input_done), .i_mode(mode),
      .o_qry_vld(b_qry_vld), .o_qry_src(b_src), .o_qry_dst(b_dst), .i_qry_rdy(qry_rdy),
      .i_cnt_vld(cnt_vld), .i_cnt(cnt[7:0]), .o_result(b_result), .o_result_vld(b_result_vld),
      .o_overflow(b_overflow), .o_error(b_error)
   );

   assign m_qry_vld    = use8 ? b_qry_vld    : a_qry_vld;
   assign m_src        = use8 ? b_src        : a_src;
   assign m_dst        = use8 ? b_dst        : a_dst;
   assign m_result     = use8 ? {56'd0, b_result} : a_result;
   assign m_result_vld = use8 ? b_result_vld : a_result_vld;
   assign m_overflow   = use8 ? b_overflow   : a_overflow;
   assign m_error      = use8 ? b_error      : a_error;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: pops expectations whenever the selected DUT presents a query or a result.
   always @(negedge clk) begin
      if (m_qry_vld && qry_rdy) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL query_unexpected got=%0h->%0h exp=none", m_src, m_dst);
         end else begin
            eq = exp_q.pop_front();
            if ({m_src, m_dst} !== eq) begin
               bad++;
               $display("FAIL query got=%0h->%0h exp=%0h->%0h", m_src, m_dst, eq[23:12], eq[11:0]);
            end
         end
      end
      if (m_result_vld) begin
         pulses++;
         total++;
         if (exp_r.size() == 0) begin
            bad++;
            $display("FAIL result_unexpected got=%0d exp=none", m_result);
         end else begin
            er = exp_r.pop_front();
            if ({m_overflow, m_result} !== er) begin
               bad++;
               $display("FAIL result got=%0d ovf=%0b exp=%0d ovf=%0b", m_result, m_overflow, er[63:0], er[64]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_qry_vld"}, 65'(m_qry_vld), 65'd0);
      chk({name, "_src"}, 65'(m_src), 65'd0);
      chk({name, "_dst"}, 65'(m_dst), 65'd0);
      chk({name, "_result"}, 65'(m_result), 65'd0);
      chk({name, "_result_vld"}, 65'(m_result_vld), 65'd0);
      chk({name, "_overflow"}, 65'(m_overflow), 65'd0);
      chk({name, "_error"}, 65'(m_error), 65'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tag = '0; tag_vld = 0; is_start = 0; is_end = 0; wp_hit = '0;
      input_done = 0; mode = 0; qry_rdy = 1; cnt_vld = 0; cnt = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic send_tag(input logic [11:0] t, input logic s, input logic e,
                           input logic [1:0] w, input logic done, input logic md);
      tag = t; tag_vld = 1; is_start = s; is_end = e; wp_hit = w;
      input_done = done; mode = md;
      @(posedge clk); #1;
      tag_vld = 0; is_start = 0; is_end = 0; wp_hit = '0; input_done = 0;
   endtask

   task automatic wait_qry(output bit ok);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m_qry_vld) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL query_timeout got=no_qry_vld exp=qry_vld");
      end
   endtask

   // Accept one query (after hold cycles of backpressure) and return its count.
   task automatic serve(input logic [63:0] c, input int hold,
                        input logic [11:0] es, input logic [11:0] ed);
      bit ok;
      qry_rdy = (hold == 0);
      wait_qry(ok);
      if (ok) begin
         repeat (hold) begin
            chk("hold_vld", 65'(m_qry_vld), 65'd1);
            chk("hold_src", 65'(m_src), 65'(es));
            chk("hold_dst", 65'(m_dst), 65'(ed));
            @(negedge clk);
         end
         if (hold > 0) begin
            @(posedge clk); #1 qry_rdy = 1;
         end
         @(posedge clk); #1;
         cnt_vld = 1; cnt = c;
         @(posedge clk); #1;
         cnt_vld = 0;
      end
   endtask

   initial begin
      int base;
      bit ok;
      use8 = 0;
      do_reset();
      @(negedge clk);
      chk_idle("reset");

      // Direct mode, end tag arriving together with input_done.
      @(posedge clk); #1;
      send_tag(12'h011, 1, 0, 2'b00, 0, 0);
      exp_q.push_back({12'h011, 12'h022});
      exp_r.push_back({1'b0, 64'd7});
      send_tag(12'h022, 0, 1, 2'b00, 1, 0);
      serve(64'd7, 0, 12'h011, 12'h022);
      @(negedge clk);
      chk("direct_result_vld", 65'(m_result_vld), 65'd1);

      // Chained 5*3*2 with backpressure on the first segment.
      do_reset();
      send_tag(12'h101, 1, 0, 2'b00, 0, 0);
      send_tag(12'h202, 0, 0, 2'b01, 0, 0);
      send_tag(12'h303, 0, 0, 2'b10, 0, 0);
      exp_q.push_back({12'h101, 12'h202});
      exp_q.push_back({12'h202, 12'h303});
      exp_q.push_back({12'h303, 12'h404});
      exp_r.push_back({1'b0, 64'd30});
      base = pulses;
      send_tag(12'h404, 0, 1, 2'b00, 1, 1);
      serve(64'd5, 5, 12'h101, 12'h202);
      serve(64'd3, 0, 12'h202, 12'h303);
      serve(64'd2, 0, 12'h303, 12'h404);
      repeat (4) @(negedge clk);
      chk("chain_pulses", 65'(pulses - base), 65'd1);
      chk("chain_hold", 65'(m_result), 65'd30);

      // Early exit on a zero count.
      do_reset();
      send_tag(12'h101, 1, 0, 2'b00, 0, 0);
      send_tag(12'h202, 0, 0, 2'b01, 0, 0);
      send_tag(12'h303, 0, 0, 2'b10, 0, 0);
      exp_q.push_back({12'h101, 12'h202});
      exp_r.push_back({1'b0, 64'd0});
      send_tag(12'h404, 0, 1, 2'b00, 1, 1);
      serve(64'd0, 0, 12'h101, 12'h202);
      repeat (5) @(negedge clk);
      chk("early_no_qry", 65'(m_qry_vld), 65'd0);

      // Overflow on the 8-bit instance: 20*20 = 400 -> 144.
      use8 = 1;
      do_reset();
      send_tag(12'h0a1, 1, 0, 2'b00, 0, 0);
      send_tag(12'h0b2, 0, 0, 2'b01, 0, 0);
      exp_q.push_back({12'h0a1, 12'h0b2});
      exp_q.push_back({12'h0b2, 12'h0c3});
      exp_r.push_back({1'b1, 64'd144});
      send_tag(12'h0c3, 0, 1, 2'b00, 1, 1);
      serve(64'd20, 0, 12'h0a1, 12'h0b2);
      serve(64'd20, 0, 12'h0b2, 12'h0c3);
      repeat (2) @(negedge clk);
      chk("ovf_sticky", 65'(m_overflow), 65'd1);
      @(posedge clk); #1;
      use8 = 0;

      // Missing waypoint 1 in chained mode.
      do_reset();
      send_tag(12'h101, 1, 0, 2'b00, 0, 0);
      send_tag(12'h202, 0, 0, 2'b01, 0, 0);
      base = pulses;
      send_tag(12'h404, 0, 1, 2'b00, 1, 1);
      @(negedge clk);
      chk("missing_error", 65'(m_error), 65'd1);
      chk("missing_no_qry", 65'(m_qry_vld), 65'd0);
      repeat (5) @(negedge clk);
      chk("missing_no_result", 65'(pulses - base), 65'd0);
      chk("missing_error_sticky", 65'(m_error), 65'd1);

      // Same stimulus in direct mode succeeds.
      do_reset();
      send_tag(12'h101, 1, 0, 2'b00, 0, 0);
      send_tag(12'h202, 0, 0, 2'b01, 0, 0);
      exp_q.push_back({12'h101, 12'h404});
      exp_r.push_back({1'b0, 64'd9});
      send_tag(12'h404, 0, 1, 2'b00, 1, 0);
      serve(64'd9, 0, 12'h101, 12'h404);
      @(negedge clk);
      chk("direct_ok_error", 65'(m_error), 65'd0);

      // Reset during WAIT_CNT, then a stray count.
      do_reset();
      send_tag(12'h101, 1, 0, 2'b00, 0, 0);
      exp_q.push_back({12'h101, 12'h404});
      send_tag(12'h404, 0, 1, 2'b00, 1, 0);
      wait_qry(ok);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle("async_reset");
      @(posedge clk); #1;
      rst = 1'b1;
      base = pulses;
      cnt_vld = 1; cnt = 64'd5;
      @(posedge clk); #1;
      cnt_vld = 0;
      repeat (3) @(negedge clk);
      chk("post_reset_no_result", 65'(pulses - base), 65'd0);
      chk_idle("post_reset");

      chk("query_queue_empty", 65'(exp_q.size()), 65'd0);
      chk("result_queue_empty", 65'(exp_r.size()), 65'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
